// File: rtl/gdp_stats_fetcher.sv
// GDP stats supplier: reads per-senone {k, mean[d], omega[d]} from a synchronous stats ROM and
// queues complete sets in a 2-entry FIFO. Optional stall counter: define STATS_STALL_COUNT_EN.
module gdp_stats_fetcher #(
    parameter int N_DIM     = 26,
    parameter int N_SENONES = 256,
    parameter int ADDR_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               first_senone,
    input  logic [8:0]               num_senones,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [15:0]              mem_data,
    output logic signed [15:0]       mean,
    output logic signed [15:0]       omega,
    output logic signed [15:0]       k,
    output logic [7:0]               stats_senone,
    output logic [4:0]               stats_dim,
    output logic                     new_stats_available,
    input  logic                     get_new_stats,
    output logic                     fetch_idle,
    output logic                     stats_underflow
`ifdef STATS_STALL_COUNT_EN
    ,
    output logic [15:0]              stall_count
`endif
);

    localparam int STRIDE = 2 * N_DIM + 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_K,
        READ_MEAN,
        READ_OMEGA,
        WAIT_SPACE,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        RET_NONE,
        RET_K,
        RET_MEAN,
        RET_OMEGA
    } ret_t;

    typedef struct packed {
        logic [15:0] mean;
        logic [15:0] omega;
        logic [15:0] k;
        logic [7:0]  senone;
        logic [4:0]  dim;
    } set_t;

    state_t              state_reg;
    logic [7:0]          cur_senone_reg;
    logic [4:0]          cur_dim_reg;
    logic [8:0]          left_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [1:0]          reserved_reg;
    logic [1:0]          count_reg;
    ret_t                ret_kind_reg;
    logic [7:0]          ret_senone_reg;
    logic [4:0]          ret_dim_reg;
    logic [15:0]         k_reg;
    logic [15:0]         mean_hold_reg;
    set_t                head_reg;
    set_t                tail_reg;
    logic                underflow_reg;

    logic                pop;
    logic                push;
    logic                space_ok;
    logic                last_dim;
    logic                last_senone;
    logic                issue_mean;
    logic [1:0]          reserved_next;
    logic [4:0]          dim_inc;
    logic [7:0]          next_senone;
    logic [ADDR_W-1:0]   mean_addr_cur;
    logic [ADDR_W-1:0]   mean_addr_inc;
    logic [ADDR_W-1:0]   omega_addr;
    set_t                in_set;

    function automatic logic [ADDR_W-1:0] base_of(input logic [7:0] s);
        return ADDR_W'(s) * ADDR_W'(STRIDE);
    endfunction

    // reserved_reg counts queued sets plus sets whose mean read is already issued,
    // so a mean read is only started when its set is guaranteed a FIFO slot.
    always_comb begin
        pop           = get_new_stats && (count_reg != 2'd0);
        push          = (ret_kind_reg == RET_OMEGA);
        space_ok      = (2'(reserved_reg - 2'(pop)) < 2'd2);
        last_dim      = (cur_dim_reg == 5'(N_DIM - 1));
        last_senone   = (left_reg == 9'd1);
        dim_inc       = cur_dim_reg + 5'd1;
        next_senone   = (cur_senone_reg == 8'(N_SENONES - 1)) ? 8'd0 : cur_senone_reg + 8'd1;
        mean_addr_cur = base_reg + ADDR_W'(1) + ADDR_W'({cur_dim_reg, 1'b0});
        mean_addr_inc = base_reg + ADDR_W'(1) + ADDR_W'({dim_inc, 1'b0});
        omega_addr    = base_reg + ADDR_W'(2) + ADDR_W'({cur_dim_reg, 1'b0});
        issue_mean    = 1'b0;
        case (state_reg)
            READ_K, WAIT_SPACE: issue_mean = space_ok;
            READ_OMEGA:         issue_mean = space_ok && !last_dim;
            default:            issue_mean = 1'b0;
        endcase
        reserved_next = 2'(reserved_reg - 2'(pop) + 2'(issue_mean));
        in_set        = '{mean: mean_hold_reg, omega: mem_data, k: k_reg,
                          senone: ret_senone_reg, dim: ret_dim_reg};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cur_senone_reg <= 8'd0;
            cur_dim_reg    <= 5'd0;
            left_reg       <= 9'd0;
            base_reg       <= '0;
            reserved_reg   <= 2'd0;
            mem_rd         <= 1'b0;
            mem_addr       <= '0;
        end else begin
            mem_rd       <= 1'b0;
            reserved_reg <= reserved_next;
            case (state_reg)
                IDLE: begin
                    if (start && (count_reg == 2'd0) && (num_senones != 9'd0)) begin
                        cur_senone_reg <= first_senone;
                        cur_dim_reg    <= 5'd0;
                        left_reg       <= (num_senones > 9'd256) ? 9'd256 : num_senones;
                        base_reg       <= base_of(first_senone);
                        mem_rd         <= 1'b1;
                        mem_addr       <= base_of(first_senone);
                        state_reg      <= READ_K;
                    end
                end
                READ_K, WAIT_SPACE: begin
                    if (issue_mean) begin
                        mem_rd    <= 1'b1;
                        mem_addr  <= mean_addr_cur;
                        state_reg <= READ_MEAN;
                    end else begin
                        state_reg <= WAIT_SPACE;
                    end
                end
                READ_MEAN: begin
                    mem_rd    <= 1'b1;
                    mem_addr  <= omega_addr;
                    state_reg <= READ_OMEGA;
                end
                READ_OMEGA: begin
                    if (last_dim) begin
                        cur_dim_reg <= 5'd0;
                        if (last_senone) begin
                            state_reg <= DRAIN;
                        end else begin
                            cur_senone_reg <= next_senone;
                            left_reg       <= left_reg - 9'd1;
                            base_reg       <= base_of(next_senone);
                            mem_rd         <= 1'b1;
                            mem_addr       <= base_of(next_senone);
                            state_reg      <= READ_K;
                        end
                    end else begin
                        cur_dim_reg <= dim_inc;
                        if (issue_mean) begin
                            mem_rd    <= 1'b1;
                            mem_addr  <= mean_addr_inc;
                            state_reg <= READ_MEAN;
                        end else begin
                            state_reg <= WAIT_SPACE;
                        end
                    end
                end
                DRAIN: begin
                    if (reserved_next == 2'd0) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The state register names the read on the bus this cycle; its data returns next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ret_kind_reg   <= RET_NONE;
            ret_senone_reg <= 8'd0;
            ret_dim_reg    <= 5'd0;
            k_reg          <= 16'd0;
            mean_hold_reg  <= 16'd0;
        end else begin
            case (state_reg)
                READ_K:     ret_kind_reg <= RET_K;
                READ_MEAN:  ret_kind_reg <= RET_MEAN;
                READ_OMEGA: ret_kind_reg <= RET_OMEGA;
                default:    ret_kind_reg <= RET_NONE;
            endcase
            ret_senone_reg <= cur_senone_reg;
            ret_dim_reg    <= cur_dim_reg;
            if (ret_kind_reg == RET_K) begin
                k_reg <= mem_data;
            end
            if (ret_kind_reg == RET_MEAN) begin
                mean_hold_reg <= mem_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= 2'd0;
            underflow_reg <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_reg == 2'd0) begin
                        head_reg <= in_set;
                    end else begin
                        tail_reg <= in_set;
                    end
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    head_reg  <= tail_reg;
                    count_reg <= count_reg - 2'd1;
                end
                2'b11: begin
                    if (count_reg == 2'd1) begin
                        head_reg <= in_set;
                    end else begin
                        head_reg <= tail_reg;
                        tail_reg <= in_set;
                    end
                end
                default: ;
            endcase
            if (get_new_stats && (count_reg == 2'd0)) begin
                underflow_reg <= 1'b1;
            end
        end
    end

`ifdef STATS_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= 16'd0;
        end else if ((state_reg == IDLE) && start && (count_reg == 2'd0) && (num_senones != 9'd0)) begin
            stall_count <= 16'd0;
        end else if ((state_reg != IDLE) && (count_reg == 2'd0) && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

    assign mean                = head_reg.mean;
    assign omega               = head_reg.omega;
    assign k                   = head_reg.k;
    assign stats_senone        = head_reg.senone;
    assign stats_dim           = head_reg.dim;
    assign new_stats_available = (count_reg != 2'd0);
    assign fetch_idle          = (state_reg == IDLE) && (count_reg == 2'd0);
    assign stats_underflow     = underflow_reg;

endmodule

// File: tb/tb_gdp_stats_fetcher.sv
// Directed bench for gdp_stats_fetcher with a 1-cycle-latency stats ROM whose word at
// address a is a*3 + 0x1234; every expected set is rebuilt from that formula.
module tb_gdp_stats_fetcher;

    logic               clk;
    logic               reset;
    logic               start;
    logic [7:0]         first_senone;
    logic [8:0]         num_senones;
    logic               mem_rd;
    logic [15:0]        mem_addr;
    logic [15:0]        mem_data;
    logic signed [15:0] mean;
    logic signed [15:0] omega;
    logic signed [15:0] k;
    logic [7:0]         stats_senone;
    logic [4:0]         stats_dim;
    logic               new_stats_available;
    logic               get_new_stats;
    logic               fetch_idle;
    logic               stats_underflow;
`ifdef STATS_STALL_COUNT_EN
    logic [15:0]        stall_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    logic [15:0] addr_log[$];
    bit          log_en = 0;

    gdp_stats_fetcher dut (
`ifdef STATS_STALL_COUNT_EN
        .stall_count         (stall_count),
`endif
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .first_senone        (first_senone),
        .num_senones         (num_senones),
        .mem_rd              (mem_rd),
        .mem_addr            (mem_addr),
        .mem_data            (mem_data),
        .mean                (mean),
        .omega               (omega),
        .k                   (k),
        .stats_senone        (stats_senone),
        .stats_dim           (stats_dim),
        .new_stats_available (new_stats_available),
        .get_new_stats       (get_new_stats),
        .fetch_idle          (fetch_idle),
        .stats_underflow     (stats_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input int a);
        return 16'(a * 3 + 32'h1234);
    endfunction

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_data <= rom(int'(mem_addr));
            if (log_en) addr_log.push_back(mem_addr);
        end
    end

    function automatic logic [63:0] exp_set(input int s, input int d);
        int b;
        b = s * 53;
        return {3'b0, 8'(s), 5'(d), rom(b + 1 + 2 * d), rom(b + 2 + 2 * d), rom(b)};
    endfunction

    function automatic logic [63:0] obs_set();
        return {3'b0, stats_senone, stats_dim, mean, omega, k};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input int first, input int num);
        first_senone = 8'(first);
        num_senones  = 9'(num);
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    // Wait for a head set, check it, then pop it with a single-cycle pulse.
    task automatic consume(input int s, input int d);
        int n;
        n = 0;
        while (!new_stats_available && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_set", 64'(new_stats_available), 64'd1);
        chk("set", obs_set(), exp_set(s, d));
        get_new_stats = 1'b1;
        @(negedge clk);
        get_new_stats = 1'b0;
    endtask

    // Pop every cycle a set is visible; check the sequence against the model.
    task automatic run_stream(input int first, input int num);
        int idx;
        int cyc;
        int total;
        idx   = 0;
        cyc   = 0;
        total = num * 26;
        while (idx < total && cyc < 2000) begin
            if (new_stats_available) begin
                chk("stream", obs_set(), exp_set((first + idx / 26) % 256, idx % 26));
                idx++;
                get_new_stats = 1'b1;
            end else begin
                get_new_stats = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        get_new_stats = 1'b0;
        chk("stream_count", 64'(idx), 64'(total));
        cyc = 0;
        while (!fetch_idle && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("stream_idle", 64'(fetch_idle), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        get_new_stats = 1'b0;
        first_senone  = 8'd0;
        num_senones   = 9'd0;
        repeat (2) @(negedge clk);
        chk("rst_idle", 64'(fetch_idle), 64'd1);
        chk("rst_nsa", 64'(new_stats_available), 64'd0);
        chk("rst_mem_rd", 64'(mem_rd), 64'd0);
        chk("rst_underflow", 64'(stats_underflow), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single senone 2, pulsed consumption with gaps.
        do_start(2, 1);
        chk("first_rd", 64'(mem_rd), 64'd1);
        chk("first_addr", 64'(mem_addr), 64'd106);
        repeat (3) @(negedge clk);
        chk("latency_before", 64'(new_stats_available), 64'd0);
        @(negedge clk);
        chk("latency_at", 64'(new_stats_available), 64'd1);
        chk("s2_k", 64'(k), 64'd4978);
        chk("s2_mean0", 64'(mean), 64'd4981);
        chk("s2_omega0", 64'(omega), 64'd4984);
        for (int d = 0; d < 26; d++) consume(2, d);
        chk("s2_idle", 64'(fetch_idle), 64'd1);
        chk("s2_nsa", 64'(new_stats_available), 64'd0);

        // Two senones from 0, consumer pops every cycle a set is visible.
        do_start(0, 2);
        run_stream(0, 2);
        chk("s0_underflow", 64'(stats_underflow), 64'd0);

        // Senone wrap 255 -> 0.
        addr_log.delete();
        log_en = 1;
        do_start(255, 2);
        run_stream(255, 2);
        log_en = 0;
        chk("wrap_reads", 64'(addr_log.size()), 64'd106);
        chk("wrap_k0_addr", 64'(addr_log[0]), 64'd13515);
        chk("wrap_last_omega", 64'(addr_log[52]), 64'd13567);
        chk("wrap_k1_addr", 64'(addr_log[53]), 64'd0);

        // Underflow pulse before the first set; run must be unaffected.
        do_start(5, 1);
        get_new_stats = 1'b1;
        @(negedge clk);
        get_new_stats = 1'b0;
        chk("underflow_set", 64'(stats_underflow), 64'd1);
        run_stream(5, 1);
        chk("underflow_sticky", 64'(stats_underflow), 64'd1);

        // Reset mid-run at dim 10, then restart.
        do_start(3, 1);
        for (int d = 0; d < 10; d++) consume(3, d);
        for (int n = 0; n < 50 && !new_stats_available; n++) @(negedge clk);
        chk("mid_dim", 64'(stats_dim), 64'd10);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_nsa", 64'(new_stats_available), 64'd0);
        chk("mid_rst_idle", 64'(fetch_idle), 64'd1);
        chk("mid_rst_underflow", 64'(stats_underflow), 64'd0);
`ifdef STATS_STALL_COUNT_EN
        chk("mid_rst_stall", 64'(stall_count), 64'd0);
`endif
        reset = 1'b1;
        @(negedge clk);
        do_start(3, 1);
        run_stream(3, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
